// File: rtl/twos_pkg.sv
// rtl/twos_pkg.sv - shared state encoding and mode constants for the serial two's-complement block
package twos_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_NEG = 1'b0;
  localparam logic MODE_ABS = 1'b1;

endpackage

// File: rtl/twos_serial_cell.sv
// rtl/twos_serial_cell.sv - per-bit invert-after-first-one cell with its seen_one flop
module twos_serial_cell (
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  input  logic invert_en,
  input  logic clear,
  input  logic enable,
  output logic res_bit
);

  logic seen_one;

  // Bits up to and including the first one pass unchanged; later bits flip.
  assign res_bit = bit_in ^ (invert_en & seen_one);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_one <= 1'b0;
    end else if (clear) begin
      seen_one <= 1'b0;
    end else if (enable) begin
      seen_one <= seen_one | bit_in;
    end
  end

endmodule

// File: rtl/twos_complement_serial.sv
// rtl/twos_complement_serial.sv - bit-serial negate / absolute value with valid-ready handshakes
module twos_complement_serial
  import twos_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0]    LAST_IDX = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] shreg;
  logic             invert_en;
  logic [IW-1:0]    idx;
  logic             accept;
  logic             run_en;
  logic             last_bit;
  logic             res_bit;

  assign accept   = in_valid & in_ready;
  assign run_en   = (state == RUN);
  assign last_bit = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  twos_serial_cell u_cell (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (operand[idx]),
    .invert_en (invert_en),
    .clear     (accept),
    .enable    (run_en),
    .res_bit   (res_bit)
  );

  // The first DONE cycle copies the finished shift register into the output
  // word, so out_data keeps the previous result until a new one is complete.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operand   <= '0;
      invert_en <= 1'b0;
      idx       <= '0;
      shreg     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (accept) begin
        operand   <= in_data;
        invert_en <= (mode == MODE_NEG) ? 1'b1 : in_data[WIDTH-1];
        idx       <= '0;
      end
      if (run_en) begin
        shreg <= {res_bit, shreg[WIDTH-1:1]};
        if (!last_bit) idx <= idx + 1'b1;
      end
      if (state == DONE && !out_valid) begin
        out_valid <= 1'b1;
        out_data  <= shreg;
        out_ovf   <= invert_en & (operand == MOST_NEG);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_twos_complement_serial.sv
// tb/tb_twos_complement_serial.sv - randomized and directed self-checking bench for twos_complement_serial
module tb_twos_complement_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_ovf;

  int n_checks = 0;
  int n_fails  = 0;

  twos_complement_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: negate or abs on the signed integer value, wrapped to W bits.
  function automatic logic [W:0] model(input logic [W-1:0] d, input logic m);
    int           v;
    logic         inv;
    logic [W-1:0] r;
    v   = int'($signed(d));
    inv = (m == 1'b0) || (v < 0);
    r   = inv ? W'(-v) : d;
    return {inv && (v == -(1 << (W - 1))), r};
  endfunction

  task automatic do_op(input logic [W-1:0] d, input logic m, input int hold,
                       output logic [W-1:0] od, output logic ov);
    int lat;
    @(negedge clk);
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    mode      = m;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
    mode     = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(W + 1));
    od = out_data;
    ov = out_ovf;
    check_eq("in_ready_done", 32'(in_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = W'($urandom);
      mode     = 1'($urandom);
      @(posedge clk); #1;
      check_eq("hold_data", 32'({out_valid, in_ready, out_ovf, out_data}), 32'({1'b1, 1'b0, ov, od}));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("release", 32'({out_valid, in_ready}), 32'b01);
    check_eq("idle_hold", 32'({out_ovf, out_data}), 32'({ov, od}));
  endtask

  logic [W-1:0] od;
  logic         ov;
  logic [W:0]   exp_r;
  bit           seen;

  typedef struct {
    logic [W-1:0] d;
    logic         m;
    int           hold;
  } vec_t;

  vec_t dir[$];

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", 32'({out_valid, out_ovf, out_data}), 32'd0);
    check_eq("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    dir.push_back('{8'h05, 1'b0, 0});
    dir.push_back('{8'hFB, 1'b1, 1});
    dir.push_back('{8'h05, 1'b1, 0});
    dir.push_back('{8'h00, 1'b0, 2});
    dir.push_back('{8'h00, 1'b1, 0});
    dir.push_back('{8'h80, 1'b0, 0});
    dir.push_back('{8'h80, 1'b1, 3});
    dir.push_back('{8'h7F, 1'b0, 0});
    dir.push_back('{8'hC3, 1'b1, 5});
    foreach (dir[i]) begin
      do_op(dir[i].d, dir[i].m, dir[i].hold, od, ov);
      exp_r = model(dir[i].d, dir[i].m);
      check_eq($sformatf("dir_data_%0d", i), 32'(od), 32'(exp_r[W-1:0]));
      check_eq($sformatf("dir_ovf_%0d", i), 32'(ov), 32'(exp_r[W]));
    end

    // Abort mid-operation: the interrupted result must never surface.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h33;
    mode     = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("abort_reset_outputs", 32'({out_valid, out_ovf, out_data}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check_eq("abort_no_valid", 32'(seen), 32'd0);
    do_op(8'h01, 1'b0, 0, od, ov);
    check_eq("after_abort", 32'({ov, od}), 32'h0FF);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] d;
      logic         m;
      d = W'($urandom);
      m = 1'($urandom);
      do_op(d, m, $urandom_range(0, 4), od, ov);
      exp_r = model(d, m);
      check_eq("rand", 32'({ov, od}), 32'(exp_r));
    end

    for (int i = 0; i < 256; i++) begin
      for (int m = 0; m < 2; m++) begin
        do_op(W'(i), 1'(m), 0, od, ov);
        exp_r = model(W'(i), 1'(m));
        check_eq($sformatf("sweep_%0h_m%0d", i, m), 32'({ov, od}), 32'(exp_r));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/twos_complement_serial.md
TWOS_COMPLEMENT_SERIAL -- requirements
Module: twos_complement_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand offered.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand.
REQ-006 SHALL have port in_data  input  WIDTH  operand, two's-complement signed.
REQ-007 SHALL have port mode  input  1  0 = negate, 1 = absolute value; sampled with in_data.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port out_data  output  WIDTH  result word.
REQ-011 SHALL have port out_ovf  output  1  result not representable (operand is the most-negative value and inversion applied).

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid&in_ready, capture in_data and mode into an operand register, clear bit index and seen_one flag, go to RUN.
REQ-014 Invert-enable SHALL be fixed at capture: 1 for mode=0; in_data[WIDTH-1] for mode=1 (non-negative operands pass unchanged in abs mode).
REQ-015 RUN: one bit per cycle, LSB first, index 0..WIDTH-1; result bit = operand bit XOR (invert_en AND seen_one); then seen_one |= operand bit.
REQ-016 RUN SHALL last exactly WIDTH cycles; after processing index WIDTH-1, go to DONE.
REQ-017 Latency: out_valid SHALL rise exactly WIDTH+1 rising edges after the accepting edge.
REQ-018 DONE: out_valid=1, in_ready=0; out_data and out_ovf stable until the edge where out_valid&out_ready, then go to IDLE.
REQ-019 in_ready SHALL be 0 throughout RUN and DONE; no operand overlap, no internal queue.
REQ-020 out_ovf SHALL be 1 iff invert_en=1 and operand = 1 followed by WIDTH-1 zeros; out_data then equals the operand.
REQ-021 Operand 0 SHALL yield out_data=0, out_ovf=0 in both modes.
REQ-022 Result bit index wrap: index counter SHALL be clog2(WIDTH) bits wide, no modulo wrap beyond WIDTH-1.
REQ-023 in_valid and in_data changes while in_ready=0 SHALL be ignored.
REQ-024 out_data, out_ovf SHALL hold last result in IDLE until next completion (value unobservable qualifier: out_valid).

Reset
REQ-025 reset=1 SHALL immediately force: state=IDLE, in_ready=1 after release, out_valid=0, out_data=0, out_ovf=0, index=0, seen_one=0, operand=0.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation; the aborted result SHALL never be presented.
REQ-027 First operand SHALL be accepted at the first rising edge after reset deassertion with in_valid=1.

Structure
REQ-028 A shared package twos_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and mode constants MODE_NEG=0, MODE_ABS=1.
REQ-029 One sub-module, twos_serial_cell, SHALL hold the seen_one flop and the per-bit XOR logic (inputs: bit, invert_en, clear, enable; output: result bit).
REQ-030 Result SHALL be assembled in a WIDTH-bit shift register filled MSB-end, shifting right each RUN cycle.

Verification (WIDTH=8)
REQ-031 Negate 0x05 (mode=0) -> out_data=0xFB, out_ovf=0, out_valid 9 edges after accept.
REQ-032 Abs 0xFB (mode=1) -> 0x05, ovf=0; abs 0x05 -> 0x05, ovf=0; negate 0x00 -> 0x00, ovf=0.
REQ-033 Negate 0x80 and abs 0x80 -> out_data=0x80, out_ovf=1; negate 0x7F -> 0x81, ovf=0.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0, in_valid pulses ignored; then accept and return to IDLE.
REQ-035 Assert reset at RUN cycle 4 -> out_valid never rises for that operand; next operand 0x01 negate -> 0xFF.
REQ-036 Exhaustive sweep 0x00..0xFF both modes, back-to-back with out_ready=1 -> all results match reference model.
